// File: rtl/rcvr_controller_pkg.sv
// Shared definitions for the UART receive controller: state encodings, default bit timing
// and the parity-check helper. The state values must match the transmitter side.
package rcvr_controller_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SHIFT  = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    // 1 when the received parity bit disagrees with the expected sense.
    function automatic logic parity_error(input logic data_xor,
                                          input logic par_bit,
                                          input logic odd);
        return data_xor ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/rcvr_controller_bit_timer.sv
// Bit timer for the receiver: free-running counter with half-bit and full-bit
// compare strobes, cleared by the FSM on every state change.
module rcvr_controller_bit_timer
    import rcvr_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr_i,
    output logic half_tick_o,
    output logic full_tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] ctr_q;
    logic [CW-1:0] ctr_d;

    assign half_tick_o = (ctr_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick_o = (ctr_q == CW'(CLKS_PER_BIT - 1));

    // NOTE: ctr_d is assigned a default before any condition so no latch is inferred.
    always_comb begin
        ctr_d = ctr_q + 1'b1;
        // Wrapping on full_tick keeps consecutive data bits aligned for any bit length.
        if (clr_i || full_tick_o) begin
            ctr_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/rcvr_controller.sv
// UART receive controller: synchronises RxD, recovers start/data/parity/stop framing and
// presents the byte with RxRDY and error flags until the CPU acknowledges with RD.
module rcvr_controller
    import rcvr_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 RxD,
    input  logic                 RD,
    output logic [DATA_BITS-1:0] Data,
    output logic                 RxRDY,
    output logic                 PErr,
    output logic                 FErr,
    output logic                 OErr,
    output logic                 Idle
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    rx_state_e            state_q;
    rx_state_e            state_d;
    logic                 sync1_q;
    logic                 rxs_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [BCW-1:0]       bitcnt_q;
    logic                 p_err_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 rxrdy_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 oerr_q;

    logic half_tick;
    logic full_tick;
    logic timer_clr;
    logic last_bit;
    logic shift_en;
    logic load;

    rcvr_controller_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .Clock       (Clock),
        .Reset       (Reset),
        .clr_i       (timer_clr),
        .half_tick_o (half_tick),
        .full_tick_o (full_tick)
    );

    assign last_bit  = (bitcnt_q == BCW'(DATA_BITS - 1));
    assign shift_en  = (state_q == S_SHIFT) && full_tick;
    assign load      = (state_q == S_STOP) && full_tick;
    assign timer_clr = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!rxs_q) state_d = S_START;
            // A high line at mid start bit is treated as a glitch, not a frame.
            S_START:  if (half_tick) state_d = rxs_q ? S_IDLE : S_SHIFT;
            S_SHIFT:  if (full_tick && last_bit) state_d = S_PARITY;
            S_PARITY: if (full_tick) state_d = S_STOP;
            S_STOP:   if (full_tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            bitcnt_q <= '0;
            p_err_q  <= 1'b0;
            data_q   <= '0;
            rxrdy_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            sync1_q <= RxD;
            rxs_q   <= sync1_q;
            state_q <= state_d;

            if (state_q == S_START) begin
                bitcnt_q <= '0;
            end else if (shift_en) begin
                bitcnt_q <= bitcnt_q + 1'b1;
            end

            if ((state_q == S_PARITY) && full_tick) begin
                p_err_q <= parity_error(^sr_q, rxs_q, PARITY_ODD != 0);
            end

            // A new frame takes priority over a coincident read strobe.
            if (load) begin
                data_q  <= sr_q;
                rxrdy_q <= 1'b1;
                perr_q  <= p_err_q;
                ferr_q  <= ~rxs_q;
                oerr_q  <= rxrdy_q & ~RD;
            end else if (RD && rxrdy_q) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                oerr_q  <= 1'b0;
            end
        end
    end

    // NOTE: the shift register has no reset; every bit is overwritten before it is loaded into Data.
    always_ff @(posedge Clock) begin
        if (shift_en) begin
            sr_q <= DATA_BITS'({rxs_q, sr_q} >> 1);
        end
    end

    assign Data  = data_q;
    assign RxRDY = rxrdy_q;
    assign PErr  = perr_q;
    assign FErr  = ferr_q;
    assign OErr  = oerr_q;
    assign Idle  = (state_q == S_IDLE);

endmodule

// File: tb/tb_rcvr_controller.sv
// Directed bench for rcvr_controller: even- and odd-parity instances share the serial line
// and CPU strobe; expected values are hand-computed per frame.
module tb_rcvr_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       RxD   = 1'b1;
    logic       RD    = 1'b0;
    logic [7:0] data_e, data_o;
    logic       rxrdy_e, perr_e, ferr_e, oerr_e, idle_e;
    logic       rxrdy_o, perr_o, ferr_o, oerr_o, idle_o;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    rcvr_controller #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_ODD(0)) u_dut (
        .Clock (Clock), .Reset (Reset), .RxD (RxD), .RD (RD),
        .Data  (data_e), .RxRDY (rxrdy_e), .PErr (perr_e), .FErr (ferr_e),
        .OErr  (oerr_e), .Idle  (idle_e)
    );

    rcvr_controller #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_ODD(1)) u_dut_odd (
        .Clock (Clock), .Reset (Reset), .RxD (RxD), .RD (RD),
        .Data  (data_o), .RxRDY (rxrdy_o), .PErr (perr_o), .FErr (ferr_o),
        .OErr  (oerr_o), .Idle  (idle_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RxD = b;
        repeat (16) @(posedge Clock);
        @(negedge Clock);
    endtask

    // Drives start, data, parity and the first 10 clocks of stop; returns just before the load edge.
    task automatic frame_head(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        RxD = stop;
        repeat (10) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic load_edge(input logic rd_val);
        RD = rd_val;
        @(posedge Clock);
        @(negedge Clock);
        RD = 1'b0;
    endtask

    task automatic frame_tail();
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        RxD = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_data",  data_e,  8'h00);
        check("rst_rxrdy", rxrdy_e, 1'b0);
        check("rst_flags", {perr_e, ferr_e, oerr_e}, 3'b000);
        check("rst_idle",  idle_e,  1'b1);
        Reset = 1'b1;
        idle_cycles(5);

        // 1: 0xA5, parity 0, stop 1; RxRDY rises exactly at edge 170
        frame_head(8'hA5, 1'b0, 1'b1);
        check("t1_rxrdy_pre", rxrdy_e, 1'b0);
        load_edge(1'b0);
        check("t1_rxrdy",  rxrdy_e, 1'b1);
        check("t1_data",   data_e,  8'hA5);
        check("t1_flags",  {perr_e, ferr_e, oerr_e}, 3'b000);
        check("t1_idle",   idle_e,  1'b1);
        check("t1_odd_perr", perr_o, 1'b1);
        frame_tail();
        idle_cycles(20);
        load_edge(1'b1);
        check("t1_rd_rxrdy", rxrdy_e, 1'b0);
        check("t1_rd_data",  data_e,  8'hA5);

        // 2: 0x5A with parity bit 1: even instance flags, odd instance does not
        frame_head(8'h5A, 1'b1, 1'b1);
        load_edge(1'b0);
        check("t2_data",     data_e, 8'h5A);
        check("t2_perr",     perr_e, 1'b1);
        check("t2_odd_perr", perr_o, 1'b0);
        check("t2_odd_data", data_o, 8'h5A);
        frame_tail();
        idle_cycles(20);
        load_edge(1'b1);
        check("t2_rd_perr", perr_e, 1'b0);

        // 3: stop bit 0 -> framing error, then RD clears it
        frame_head(8'h81, 1'b0, 1'b0);
        load_edge(1'b0);
        check("t3_ferr",  ferr_e, 1'b1);
        check("t3_perr",  perr_e, 1'b0);
        check("t3_data",  data_e, 8'h81);
        frame_tail();
        idle_cycles(20);
        check("t3_hold_rxrdy", rxrdy_e, 1'b1);
        check("t3_idle",       idle_e,  1'b1);
        load_edge(1'b1);
        check("t3_rd_rxrdy", rxrdy_e, 1'b0);
        check("t3_rd_ferr",  ferr_e,  1'b0);
        check("t3_rd_data",  data_e,  8'h81);
        load_edge(1'b1);
        check("t3_rd_noop_data",  data_e, 8'h81);
        check("t3_rd_noop_rxrdy", rxrdy_e, 1'b0);

        // 4a: back-to-back 0x11, 0x22 without RD -> overrun
        frame_head(8'h11, 1'b0, 1'b1);
        load_edge(1'b0);
        check("t4a_first_oerr", oerr_e, 1'b0);
        frame_tail();
        frame_head(8'h22, 1'b0, 1'b1);
        load_edge(1'b0);
        check("t4a_data",  data_e,  8'h22);
        check("t4a_oerr",  oerr_e,  1'b1);
        check("t4a_rxrdy", rxrdy_e, 1'b1);
        frame_tail();
        idle_cycles(20);
        load_edge(1'b1);
        check("t4a_rd_oerr", oerr_e, 1'b0);

        // 4b: RD coincident with the second load -> load wins, no overrun
        frame_head(8'h11, 1'b0, 1'b1);
        load_edge(1'b0);
        frame_tail();
        frame_head(8'h22, 1'b0, 1'b1);
        load_edge(1'b1);
        check("t4b_rxrdy", rxrdy_e, 1'b1);
        check("t4b_oerr",  oerr_e,  1'b0);
        check("t4b_data",  data_e,  8'h22);
        frame_tail();
        idle_cycles(20);
        load_edge(1'b1);

        // 5: 4-clock low glitch -> back to idle, nothing received
        RxD = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("t5_left_idle", idle_e, 1'b0);
        RxD = 1'b1;
        idle_cycles(20);
        check("t5_idle",  idle_e,  1'b1);
        check("t5_rxrdy", rxrdy_e, 1'b0);

        // 6: reset during the 4th data bit, then a clean 0x3C frame
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        RxD = 1'b1;
        repeat (8) @(posedge Clock);
        @(negedge Clock);
        check("t6_busy", idle_e, 1'b0);
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("t6_rst_data",  data_e,  8'h00);
        check("t6_rst_flags", {rxrdy_e, perr_e, ferr_e, oerr_e}, 4'b0000);
        check("t6_rst_idle",  idle_e,  1'b1);
        Reset = 1'b1;
        RxD   = 1'b1;
        idle_cycles(20);
        frame_head(8'h3C, 1'b0, 1'b1);
        load_edge(1'b0);
        check("t6_data",  data_e,  8'h3C);
        check("t6_rxrdy", rxrdy_e, 1'b1);
        check("t6_flags", {perr_e, ferr_e, oerr_e}, 3'b000);
        frame_tail();
        idle_cycles(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
